qam16_upsampler: RTL
====================

# qam16_upsampler

Transmit-side stage directly upstream of `rrc_filter`: accepts 4-bit 16-QAM symbols through a valid/ready handshake and buffers them in a 2-entry FIFO. It Gray-maps each symbol to Q1.11 I/Q levels and zero-stuffs it to `SPS` samples per symbol. The I and Q sample streams drive two `rrc_filter` instances (`din`/`din_valid`) at one sample per `sample_en` strobe. Starvation is handled by emitting zero symbols so the filters stay clocked.

## Interface
Parameters:
- `SPS`, `gdsp_pkg::SPS` (4): output samples per symbol, ≥2.
- `FIFO_DEPTH`, 2: symbol buffer entries, power of two.

Ports:
- `clk`  in  1  system clock (27 MHz).
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  run request.
- `sample_en`  in  1  sample-rate strobe; tie high for one sample per cycle.
- `sym_in`  in  4  symbol; bits [3:2] select I, bits [1:0] select Q.
- `sym_valid`  in  1  `sym_in` valid.
- `sym_ready`  out  1  FIFO can accept a symbol.
- `out_i`  out  `DATA_WIDTH` (12)  I sample, `sample_t`.
- `out_q`  out  12  Q sample, `sample_t`.
- `out_valid`  out  1  sample strobe to `rrc_filter` `din_valid`.
- `out_sym_start`  out  1  high on the phase-0 sample of each symbol period.
- `underflow`  out  1  sticky; set when phase 0 finds the FIFO empty in RUN.
- `underflow_cnt`  out  16  saturating count of underflow events.

## Operation
- Handshake: a push occurs when `sym_valid && sym_ready`. `sym_ready = (count != FIFO_DEPTH)` and is driven from registered `count`.
- Gray mapping for each 2-bit field: 00→`-QAM_LVL_3`, 01→`-QAM_LVL_1`, 11→`+QAM_LVL_1`, 10→`+QAM_LVL_3`.
- Package constants: `QAM_LVL_1 = 12'sd324`, `QAM_LVL_3 = 12'sd972`. All values fit Q1.11 with no saturation.
- FSM IDLE:
  - `out_valid=0`, `out_i=out_q=0`, phase=0.
  - Go to RUN when `enable && count!=0`; the check happens every cycle.
- FSM RUN (phase counter advances only on `sample_en`):
  - Phase 0: pop the FIFO head and emit the mapped I/Q with `out_sym_start=1`. If the FIFO is empty, emit I=Q=0, set `underflow` and increment `underflow_cnt` (saturates at 0xFFFF).
  - Phases 1..SPS-1: emit I=Q=0.
  - Phase wraps SPS-1→0.
- Leaving RUN: if `enable` is low at the `sample_en` that completes phase SPS-1, go to IDLE. A symbol period is never truncated.
- Simultaneous push and pop in one cycle: `count` is unchanged and data order is preserved.
  - With the FIFO full, `sym_ready=0`, so the pop alone frees a slot; `sym_ready` rises the next cycle.
  - With the FIFO empty, a phase-0 pop does not bypass to the same-cycle push. The symbol is an underflow and the pushed symbol waits for the next phase 0.
- `underflow` and `underflow_cnt` clear only on reset.

## Timing
- Reset values: `sym_ready=0` during reset and 1 on the first cycle after; `out_i=out_q=0`; `out_valid=0`; `out_sym_start=0`; `underflow=0`; `underflow_cnt=0`; FSM=IDLE; phase=0; FIFO empty.
- All outputs are registered.
- Latency from `sample_en` to `out_valid` is 1 cycle. `out_valid` is exactly the registered `sample_en` while in RUN.
- Latency from push to first emitted sample, with the FSM idle and `enable=1`, `sample_en=1`:
  - cycle N: push.
  - cycle N+1: `count=1`; IDLE→RUN.
  - cycle N+2: phase-0 pop.
  - cycle N+3: `out_valid=1` with the symbol.
- Sustained rate: one symbol per SPS strobes. A producer that pushes whenever `sym_ready` is high never underflows.
- Reset asserted mid-symbol: the next edge aborts the period, empties the FIFO and forces outputs to their reset values. No partial symbol is emitted after reset.

## Structure
- Add to `gdsp_pkg`:
  - `QAM_LVL_1`, `QAM_LVL_3`.
  - `qam16_sym_t` (logic [3:0]).
  - function `qam16_gray_map(logic [1:0]) → sample_t`.
  - reuse `SPS`, `DATA_WIDTH`, `sample_t`.
- One sub-module, `sym_fifo`: synchronous FIFO of width 4 and depth `FIFO_DEPTH`, with a count output and first-word-fall-through read.
- The top level holds the FSM, the phase counter, mapping and the output registers.

## Test plan
- Reset then symbol 4'b1001, `sample_en=1`, `enable=1`:
  - Output is I=+972, Q=-324 with `out_sym_start=1`, then three zero samples.
  - First `out_valid` appears 3 cycles after the push.
- Stream all 16 symbols 0..15 back-to-back:
  - Each phase-0 sample matches the Gray table.
  - No `underflow`; `sym_ready` toggles so that exactly one push is accepted per 4 samples.
- Push one symbol, then stall the producer for 12 cycles:
  - Three underflow periods (zero I/Q) occur, with `underflow=1` and `underflow_cnt=3`.
  - `out_valid` stays continuous.
- `sample_en` asserted every third cycle:
  - Outputs advance only on strobes, so each symbol spans 12 cycles and `out_valid` is high 4 times.
- Drop `enable` at phase 1:
  - Phases 2 and 3 still emit, then the FSM goes to IDLE with `out_valid=0`.
  - Buffered symbols remain and are emitted after `enable` returns.
- Assert `rst_n=0` at phase 2 with the FIFO full:
  - The next cycle shows all outputs at reset values and `count=0`.
  - After release, the first push produces the correct symbol with 3-cycle latency.
- End-to-end:
  - Drive two `rrc_filter` instances from the `qam16_symbols` I/Q vectors.
  - The I output must match `tx_filtered_I` within ±1 LSB.

Source files
------------

// File: rtl/gdsp_pkg.sv
// Shared DSP datapath types and constants, including the 16-QAM Gray mapping
// used by the transmit upsampler.
package gdsp_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int SPS        = 4;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic [3:0]                   qam16_sym_t;

    localparam sample_t QAM_LVL_1 = 12'sd324;
    localparam sample_t QAM_LVL_3 = 12'sd972;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ups_state_t;

    // Gray-coded axis level: adjacent levels differ in one bit
    function automatic sample_t qam16_gray_map(input logic [1:0] bits);
        sample_t lvl;
        case (bits)
            2'b00:   lvl = -QAM_LVL_3;
            2'b01:   lvl = -QAM_LVL_1;
            2'b11:   lvl = QAM_LVL_1;
            default: lvl = QAM_LVL_3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/qam16_upsampler_sym_fifo.sv
// Small synchronous symbol FIFO with first-word-fall-through read and an
// occupancy count; the caller guarantees no push when full and no pop when empty.
module sym_fifo
    import gdsp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  qam16_sym_t                   din,
    input  logic                         pop,
    output qam16_sym_t                   dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    qam16_sym_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_d, wr_ptr_q;
    logic [AW-1:0]   rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]   count_d, count_q;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/qam16_upsampler.sv
// 16-QAM symbol mapper and zero-stuffing upsampler feeding the I/Q RRC filters;
// starved symbol periods are filled with zeros and counted as underflows.
module qam16_upsampler
    import gdsp_pkg::*;
#(
    parameter int SPS        = gdsp_pkg::SPS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_en,
    input  qam16_sym_t  sym_in,
    input  logic        sym_valid,
    output logic        sym_ready,
    output sample_t     out_i,
    output sample_t     out_q,
    output logic        out_valid,
    output logic        out_sym_start,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PH_W = $clog2(SPS);

    ups_state_t      state_d, state_q;
    logic [PH_W-1:0] phase_d, phase_q;
    sample_t         out_i_d, out_i_q, out_q_d, out_q_q;
    logic            out_valid_d, out_valid_q;
    logic            out_sym_start_d, out_sym_start_q;
    logic            underflow_d, underflow_q;
    logic [15:0]     underflow_cnt_d, underflow_cnt_q;
    logic            sym_ready_d, sym_ready_q;

    logic            push, pop;
    qam16_sym_t      head;
    logic [CW-1:0]   fifo_count, count_next;

    assign push = sym_valid && sym_ready_q;

    sym_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (sym_in),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count)
    );

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        out_i_d         = '0;
        out_q_d         = '0;
        out_valid_d     = 1'b0;
        out_sym_start_d = 1'b0;
        underflow_d     = underflow_q;
        underflow_cnt_d = underflow_cnt_q;
        pop             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (enable && fifo_count != '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (sample_en) begin
                    out_valid_d = 1'b1;
                    if (phase_q == '0) begin
                        out_sym_start_d = 1'b1;
                        // An empty FIFO never bypasses a same-cycle push
                        if (fifo_count != '0) begin
                            pop     = 1'b1;
                            out_i_d = qam16_gray_map(head[3:2]);
                            out_q_d = qam16_gray_map(head[1:0]);
                        end else begin
                            underflow_d = 1'b1;
                            if (underflow_cnt_q != 16'hFFFF)
                                underflow_cnt_d = underflow_cnt_q + 16'd1;
                        end
                    end
                    if (phase_q == PH_W'(SPS - 1)) begin
                        phase_d = '0;
                        if (!enable) state_d = ST_IDLE;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is registered from the FIFO's next occupancy so it tracks count exactly
    always_comb begin
        case ({push, pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase
        sym_ready_d = (count_next != CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            phase_q         <= '0;
            out_i_q         <= '0;
            out_q_q         <= '0;
            out_valid_q     <= 1'b0;
            out_sym_start_q <= 1'b0;
            underflow_q     <= 1'b0;
            underflow_cnt_q <= '0;
            sym_ready_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            out_i_q         <= out_i_d;
            out_q_q         <= out_q_d;
            out_valid_q     <= out_valid_d;
            out_sym_start_q <= out_sym_start_d;
            underflow_q     <= underflow_d;
            underflow_cnt_q <= underflow_cnt_d;
            sym_ready_q     <= sym_ready_d;
        end
    end

    assign sym_ready     = sym_ready_q;
    assign out_i         = out_i_q;
    assign out_q         = out_q_q;
    assign out_valid     = out_valid_q;
    assign out_sym_start = out_sym_start_q;
    assign underflow     = underflow_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule
